// File: rtl/id_ex_pipe_stage_pkg.sv
// Shared definitions for the ID->EX pipeline stage: default word width,
// slot FSM states and the side-effect bundle layout.
package riscv_defines;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic       write_en;
        logic [1:0] store_type;
    } se_t;

    localparam int SE_WIDTH = $bits(se_t);

endpackage

// File: rtl/id_ex_pipe_stage_fwd_mux.sv
// Priority select of one operand between the register-file value and
// NUM_FWD forwarding sources; source 0 is the youngest and wins.
module fwd_mux #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_FWD    = 2
) (
    input  logic [WORD_WIDTH-1:0]         opnd,
    input  logic [NUM_FWD*WORD_WIDTH-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]            fwd_sel,
    output logic [WORD_WIDTH-1:0]         result
);

    // Walk from the oldest source down so the lowest set index is applied last.
    always_comb begin
        result = opnd;
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            if (fwd_sel[j]) begin
                result = fwd_data[j*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake and a one-deep skid slot.
// Optional build macro ID_EX_STALL_CNT_EN adds stall_cnt_o (downstream stall cycles).
module id_ex_pipe_stage #(
    parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
    parameter int CTRL_WIDTH = 16,
    parameter int SE_WIDTH   = riscv_defines::SE_WIDTH,
    parameter int NUM_OPS    = 2,
    parameter int NUM_FWD    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WORD_WIDTH-1:0]         pc_i,
    input  logic [WORD_WIDTH-1:0]         instr_i,
    input  logic [CTRL_WIDTH-1:0]         ctrl_i,
    input  logic [SE_WIDTH-1:0]           se_i,
    input  logic [NUM_OPS*WORD_WIDTH-1:0] opnd_i,
    input  logic [NUM_FWD*WORD_WIDTH-1:0] fwd_data_i,
    input  logic [NUM_OPS*NUM_FWD-1:0]    fwd_sel_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [WORD_WIDTH-1:0]         pc_o,
    output logic [WORD_WIDTH-1:0]         instr_o,
    output logic [CTRL_WIDTH-1:0]         ctrl_o,
    output logic [SE_WIDTH-1:0]           se_o,
    output logic [NUM_OPS*WORD_WIDTH-1:0] opnd_o
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt_o
`endif
);

    import riscv_defines::*;

    localparam int OPND_W = NUM_OPS * WORD_WIDTH;
    localparam int SLOT_W = 2 * WORD_WIDTH + CTRL_WIDTH + SE_WIDTH + OPND_W;

    pipe_state_e         state, state_next;
    logic [OPND_W-1:0]   fwd_opnd;
    logic [SLOT_W-1:0]   in_slot, main_slot, skid_slot;
    logic [SE_WIDTH-1:0] main_se;
    logic                accept, hand_off;
    logic                load_main_in, load_main_skid, load_skid;

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_fwd
        fwd_mux #(
            .WORD_WIDTH (WORD_WIDTH),
            .NUM_FWD    (NUM_FWD)
        ) u_fwd_mux (
            .opnd     (opnd_i[k*WORD_WIDTH +: WORD_WIDTH]),
            .fwd_data (fwd_data_i),
            .fwd_sel  (fwd_sel_i[k*NUM_FWD +: NUM_FWD]),
            .result   (fwd_opnd[k*WORD_WIDTH +: WORD_WIDTH])
        );
    end

    assign in_slot  = {pc_i, instr_i, ctrl_i, se_i, fwd_opnd};
    assign valid_o  = (state != EMPTY);
    assign accept   = valid_i & ready_o;
    assign hand_off = valid_o & ready_i;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = FULL;
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (accept && hand_off) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_next = SKID;
                    load_skid  = 1'b1;
                end else if (hand_off) begin
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (hand_off) begin
                    state_next     = FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // A flush discards the slot being captured as well as everything held.
        if (flush_i) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            ready_o <= 1'b1;
        end else begin
            state   <= state_next;
            ready_o <= (state_next != SKID);
        end
    end

    // NOTE: slot data is reset too, so a reset mid-transfer leaves no stale output value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_slot <= '0;
            skid_slot <= '0;
        end else begin
            if (load_main_in) begin
                main_slot <= in_slot;
            end else if (load_main_skid) begin
                main_slot <= skid_slot;
            end
            if (load_skid) begin
                skid_slot <= in_slot;
            end
        end
    end

    assign {pc_o, instr_o, ctrl_o, main_se, opnd_o} = main_slot;

    // Side effects must never leak out of an empty slot.
    assign se_o = valid_o ? main_se : '0;

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed self-checking bench for id_ex_pipe_stage (default parameters).
module tb_id_ex_pipe_stage;

    localparam int W  = 32;
    localparam int CW = 16;
    localparam int SW = 3;
    localparam int NO = 2;
    localparam int NF = 2;

    logic            clk;
    logic            rst_n;
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [W-1:0]    pc_i;
    logic [W-1:0]    instr_i;
    logic [CW-1:0]   ctrl_i;
    logic [SW-1:0]   se_i;
    logic [NO*W-1:0] opnd_i;
    logic [NF*W-1:0] fwd_data_i;
    logic [NO*NF-1:0] fwd_sel_i;
    logic            valid_o;
    logic            ready_i;
    logic [W-1:0]    pc_o;
    logic [W-1:0]    instr_o;
    logic [CW-1:0]   ctrl_o;
    logic [SW-1:0]   se_o;
    logic [NO*W-1:0] opnd_o;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]     stall_cnt_o;
`endif

    int vectors;
    int miscompares;

    id_ex_pipe_stage #(
        .WORD_WIDTH (W),
        .CTRL_WIDTH (CW),
        .SE_WIDTH   (SW),
        .NUM_OPS    (NO),
        .NUM_FWD    (NF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .ctrl_i     (ctrl_i),
        .se_i       (se_i),
        .opnd_i     (opnd_i),
        .fwd_data_i (fwd_data_i),
        .fwd_sel_i  (fwd_sel_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .pc_o       (pc_o),
        .instr_o    (instr_o),
        .ctrl_o     (ctrl_o),
        .se_o       (se_o),
        .opnd_o     (opnd_o)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_slot(input logic [W-1:0] pc, input logic v);
        valid_i   = v;
        pc_i      = pc;
        instr_i   = ~pc;
        ctrl_i    = pc[CW-1:0];
        se_i      = 3'b101;
        opnd_i    = {pc + 32'h2, pc + 32'h1};
        fwd_sel_i = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; ready_i = 1'b0; fwd_data_i = '0;
        put_slot(32'h0, 1'b0);
        #12;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b want 1", ready_o); end
        vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %0h want 0", pc_o); end
        vectors++; if (instr_o !== 32'h0 || ctrl_o !== 16'h0) begin miscompares++; $display("FAIL reset_instr_ctrl: got %0h/%0h want 0/0", instr_o, ctrl_o); end
        vectors++; if (se_o !== 3'b000 || opnd_o !== 64'h0) begin miscompares++; $display("FAIL reset_se_opnd: got %0b/%0h want 0/0", se_o, opnd_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        put_slot(32'h100, 1'b1);
        ready_i = 1'b1;
        step();
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0b want 1", valid_o); end
        vectors++; if (pc_o !== 32'h100) begin miscompares++; $display("FAIL single_pc: got %0h want 100", pc_o); end
        vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %0b want 1", ready_o); end
        vectors++; if (instr_o !== 32'hFFFF_FEFF || ctrl_o !== 16'h0100) begin miscompares++; $display("FAIL single_instr_ctrl: got %0h/%0h want fffffeff/100", instr_o, ctrl_o); end
        vectors++; if (se_o !== 3'b101) begin miscompares++; $display("FAIL single_se: got %0b want 101", se_o); end
        vectors++; if (opnd_o !== {32'h102, 32'h101}) begin miscompares++; $display("FAIL single_opnd: got %0h want 0000010200000101", opnd_o); end
        valid_i = 1'b0;
        step();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL single_drain_valid: got %0b want 0", valid_o); end
        vectors++; if (se_o !== 3'b000) begin miscompares++; $display("FAIL single_drain_se: got %0b want 0", se_o); end
        vectors++; if (pc_o !== 32'h100) begin miscompares++; $display("FAIL single_hold_pc: got %0h want 100", pc_o); end
    endtask

    task automatic test_forwarding();
        ready_i = 1'b0;
        put_slot(32'h200, 1'b1);
        opnd_i     = {32'h22, 32'h11};
        fwd_data_i = {32'hBBBB, 32'hAAAA};
        fwd_sel_i  = 4'b0011;
        step();
        vectors++; if (opnd_o !== {32'h22, 32'hAAAA}) begin miscompares++; $display("FAIL fwd_prio: got %0h want 000000220000aaaa", opnd_o); end
        valid_i    = 1'b0;
        fwd_data_i = {32'hCCCC, 32'hDDDD};
        step();
        vectors++; if (opnd_o !== {32'h22, 32'hAAAA}) begin miscompares++; $display("FAIL fwd_no_refwd: got %0h want 000000220000aaaa", opnd_o); end
        put_slot(32'h201, 1'b1);
        opnd_i     = {32'h22, 32'h11};
        fwd_data_i = {32'hBBBB, 32'hAAAA};
        fwd_sel_i  = 4'b1000;
        ready_i    = 1'b1;
        step();
        vectors++; if (opnd_o !== {32'hBBBB, 32'h11} || pc_o !== 32'h201) begin miscompares++; $display("FAIL fwd_op1_src1: got %0h pc %0h want 0000bbbb00000011 pc 201", opnd_o, pc_o); end
        valid_i = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bit   exp_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   sent = 0;
        int   got  = 0;
        logic rdy_snap, vld_snap;
        logic [W-1:0] pc_snap;
        for (int c = 0; c < 10; c++) begin
            put_slot(32'h400 + sent, sent < 4);
            ready_i = !(c == 2 || c == 3);
            if (c < 7) begin
                vectors++;
                if (ready_o !== exp_rdy[c]) begin miscompares++; $display("FAIL b2b_ready_c%0d: got %0b want %0b", c, ready_o, exp_rdy[c]); end
            end
            rdy_snap = ready_o;
            vld_snap = valid_o;
            pc_snap  = pc_o;
            step();
            if (valid_i && rdy_snap) sent++;
            if (vld_snap && ready_i) begin
                vectors++;
                if (pc_snap !== 32'h400 + got) begin miscompares++; $display("FAIL b2b_order_%0d: got %0h want %0h", got, pc_snap, 32'h400 + got); end
                got++;
            end
        end
        vectors++; if (got != 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", got); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: got %0b want 0", valid_o); end
        valid_i = 1'b0;
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        put_slot(32'h500, 1'b1);
        step();
        put_slot(32'h501, 1'b1);
        step();
        vectors++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin miscompares++; $display("FAIL flush_pre_skid: got rdy %0b vld %0b want 0/1", ready_o, valid_o); end
        put_slot(32'h502, 1'b1);
        se_i    = 3'b111;
        flush_i = 1'b1;
        step();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %0b want 0", valid_o); end
        vectors++; if (se_o !== 3'b000) begin miscompares++; $display("FAIL flush_se: got %0b want 0", se_o); end
        vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %0b want 1", ready_o); end
        vectors++; if (pc_o !== 32'h500) begin miscompares++; $display("FAIL flush_hold_pc: got %0h want 500", pc_o); end
        step();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_beats_accept: got %0b want 0", valid_o); end
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        vectors++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_after: got vld %0b rdy %0b want 0/1", valid_o, ready_o); end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        put_slot(32'h600, 1'b1);
        step();
        put_slot(32'h601, 1'b1);
        step();
        vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_skid: got %0b want 0", ready_o); end
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        vectors++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_async: got vld %0b rdy %0b want 0/1", valid_o, ready_o); end
        vectors++; if (pc_o !== 32'h0 || opnd_o !== 64'h0 || se_o !== 3'b000) begin miscompares++; $display("FAIL rstmid_data: got pc %0h opnd %0h se %0b want 0", pc_o, opnd_o, se_o); end
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        step();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_empty: got %0b want 0", valid_o); end
        put_slot(32'h700, 1'b1);
        step();
        vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h700) begin miscompares++; $display("FAIL rstmid_resume: got vld %0b pc %0h want 1/700", valid_o, pc_o); end
        valid_i = 1'b0;
        step();
    endtask

`ifdef ID_EX_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++; if (stall_cnt_o !== 32'd0) begin miscompares++; $display("FAIL stall_reset: got %0d want 0", stall_cnt_o); end
        ready_i = 1'b0;
        put_slot(32'h800, 1'b1);
        step();
        valid_i = 1'b0;
        repeat (5) step();
        vectors++; if (stall_cnt_o !== 32'd5) begin miscompares++; $display("FAIL stall_five: got %0d want 5", stall_cnt_o); end
        ready_i = 1'b1;
        step();
        vectors++; if (stall_cnt_o !== 32'd5 || valid_o !== 1'b0) begin miscompares++; $display("FAIL stall_release: got %0d vld %0b want 5/0", stall_cnt_o, valid_o); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_forwarding();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef ID_EX_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
